sap1_controller: RTL and testbench



---
 rtl/sap1_pkg.sv | 45 ++++
 rtl/sap1_ring_counter.sv | 38 +++
 rtl/sap1_controller.sv | 104 ++++++++++
 tb/tb_sap1_controller.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sap1_pkg.sv
// Shared SAP-1 controller definitions: opcodes, one-hot T-states and the 12-bit control word layout.
package sap1_pkg;

   localparam logic [3:0] OP_LDA = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_OUT = 4'b1110;
   localparam logic [3:0] OP_HLT = 4'b1111;

   typedef enum logic [5:0] {
      T1 = 6'b000001,
      T2 = 6'b000010,
      T3 = 6'b000100,
      T4 = 6'b001000,
      T5 = 6'b010000,
      T6 = 6'b100000
   } tstate_e;

   typedef logic [11:0] cw_t;

   // Bit order matches the classic SAP-1 control word: Cp Ep nLm nCE nLi nEi nLa Ea Su Eu nLb nLo
   localparam int CW_CP  = 11;
   localparam int CW_EP  = 10;
   localparam int CW_NLM = 9;
   localparam int CW_NCE = 8;
   localparam int CW_NLI = 7;
   localparam int CW_NEI = 6;
   localparam int CW_NLA = 5;
   localparam int CW_EA  = 4;
   localparam int CW_SU  = 3;
   localparam int CW_EU  = 2;
   localparam int CW_NLB = 1;
   localparam int CW_NLO = 0;

   localparam cw_t CW_IDLE = 12'b0011_1110_0011;

   // Drive one control bit to its active level, whichever polarity it has.
   function automatic cw_t cw_on(input cw_t cw, input int pos);
      cw_t r;
      r      = cw;
      r[pos] = ~CW_IDLE[pos];
      return r;
   endfunction

endpackage

// File: rtl/sap1_ring_counter.sv
// One-hot T-state ring advancing on the falling clock edge; holds while frozen,
// and any non-one-hot value (including all-zero) recovers to T1 on the next edge.
module sap1_ring_counter
   import sap1_pkg::*;
#(
   parameter int NUM_T = 6
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_freeze,
   output logic [NUM_T-1:0] o_state
);

   localparam logic [NUM_T-1:0] ST_FIRST = NUM_T'(T1);

   logic [NUM_T-1:0] r_state;
   logic [NUM_T-1:0] w_next;

   always_ff @(negedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_FIRST;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      if (!$onehot(r_state)) begin
         w_next = ST_FIRST;
      end else if (!i_freeze) begin
         w_next = {r_state[NUM_T-2:0], r_state[NUM_T-1]};
      end
   end

   assign o_state = r_state;

endmodule

// File: rtl/sap1_controller.sv
// SAP-1 controller-sequencer: negedge T-state ring plus combinational control-word decode,
// so every control line is settled for the half cycle before the datapath posedge.
module sap1_controller
   import sap1_pkg::*;
#(
   parameter int OP_W  = 4,
   parameter int NUM_T = 6
) (
   input  logic             CLK,
   input  logic             nCLR,
   input  logic [OP_W-1:0]  OPCODE,
   output logic             Cp,
   output logic             Ep,
   output logic             nLm,
   output logic             nCE,
   output logic             nLi,
   output logic             nEi,
   output logic             nLa,
   output logic             Ea,
   output logic             Su,
   output logic             Eu,
   output logic             nLb,
   output logic             nLo,
   output logic             HLT,
   output logic [NUM_T-1:0] TSTATE
);

   logic r_halt;
   logic w_hlt_now;
   logic w_halted;
   cw_t  w_cw;

   sap1_ring_counter #(
      .NUM_T (NUM_T)
   ) u_ring (
      .i_clk    (CLK),
      .i_rst_n  (nCLR),
      .i_freeze (w_halted),
      .o_state  (TSTATE)
   );

   // Halt is visible combinationally in T4 so the ring never leaves T4; the flag then
   // latches it so later opcode changes cannot restart the machine.
   assign w_hlt_now = (TSTATE == T4) && (OPCODE == OP_HLT);
   assign w_halted  = r_halt | w_hlt_now;

   always_ff @(negedge CLK or negedge nCLR) begin
      if (!nCLR) begin
         r_halt <= 1'b0;
      end else if (w_hlt_now) begin
         r_halt <= 1'b1;
      end
   end

   always_comb begin
      w_cw = CW_IDLE;
      if (nCLR && !w_halted) begin
         case (TSTATE)
            T1: w_cw = cw_on(cw_on(CW_IDLE, CW_EP), CW_NLM);
            T2: w_cw = cw_on(CW_IDLE, CW_CP);
            T3: w_cw = cw_on(cw_on(CW_IDLE, CW_NCE), CW_NLI);
            T4: begin
               case (OPCODE)
                  OP_LDA, OP_ADD, OP_SUB: w_cw = cw_on(cw_on(CW_IDLE, CW_NEI), CW_NLM);
                  OP_OUT:                 w_cw = cw_on(cw_on(CW_IDLE, CW_EA), CW_NLO);
                  default:                w_cw = CW_IDLE;
               endcase
            end
            T5: begin
               // Su comes up here, a full state before Eu drives the difference onto the bus.
               case (OPCODE)
                  OP_LDA:  w_cw = cw_on(cw_on(CW_IDLE, CW_NCE), CW_NLA);
                  OP_ADD:  w_cw = cw_on(cw_on(CW_IDLE, CW_NCE), CW_NLB);
                  OP_SUB:  w_cw = cw_on(cw_on(cw_on(CW_IDLE, CW_NCE), CW_NLB), CW_SU);
                  default: w_cw = CW_IDLE;
               endcase
            end
            T6: begin
               case (OPCODE)
                  OP_ADD:  w_cw = cw_on(cw_on(CW_IDLE, CW_EU), CW_NLA);
                  OP_SUB:  w_cw = cw_on(cw_on(cw_on(CW_IDLE, CW_EU), CW_NLA), CW_SU);
                  default: w_cw = CW_IDLE;
               endcase
            end
            default: w_cw = CW_IDLE;
         endcase
      end
   end

   assign Cp  = w_cw[CW_CP];
   assign Ep  = w_cw[CW_EP];
   assign nLm = w_cw[CW_NLM];
   assign nCE = w_cw[CW_NCE];
   assign nLi = w_cw[CW_NLI];
   assign nEi = w_cw[CW_NEI];
   assign nLa = w_cw[CW_NLA];
   assign Ea  = w_cw[CW_EA];
   assign Su  = w_cw[CW_SU];
   assign Eu  = w_cw[CW_EU];
   assign nLb = w_cw[CW_NLB];
   assign nLo = w_cw[CW_NLO];
   assign HLT = nCLR & w_halted;

endmodule

// File: tb/tb_sap1_controller.sv
// Randomized scoreboard bench for sap1_controller with an instruction-level reference model
// and a small behavioural SAP-1 datapath for end-to-end program checks.
module tb_sap1_controller;

   logic       CLK = 1'b1;
   logic       nCLR;
   logic [3:0] op_rand;
   logic [3:0] op_w;
   logic       Cp, Ep, nLm, nCE, nLi, nEi, nLa, Ea, Su, Eu, nLb, nLo, HLT;
   logic [5:0] TSTATE;
   logic [11:0] act_cw;

   always #5 CLK = ~CLK;

   sap1_controller dut (
      .CLK    (CLK),
      .nCLR   (nCLR),
      .OPCODE (op_w),
      .Cp     (Cp),
      .Ep     (Ep),
      .nLm    (nLm),
      .nCE    (nCE),
      .nLi    (nLi),
      .nEi    (nEi),
      .nLa    (nLa),
      .Ea     (Ea),
      .Su     (Su),
      .Eu     (Eu),
      .nLb    (nLb),
      .nLo    (nLo),
      .HLT    (HLT),
      .TSTATE (TSTATE)
   );

   assign act_cw = {Cp, Ep, nLm, nCE, nLi, nEi, nLa, Ea, Su, Eu, nLb, nLo};

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [5:0]  ts;
      logic [11:0] cw;
      logic        hlt;
   } exp_t;

   exp_t       exp_q[$];
   logic [3:0] plan_q[$];

   // Instruction-level model: current T-step number, halt state, opcode of current instruction
   int         m_t;
   bit         m_halted;
   bit         m_force;
   logic [3:0] m_instr;
   bit         garbage_en;
   bit         dp_mode;
   int         hcnt;

   // Expected control word straight from the microinstruction table (step 0 = all inactive)
   function automatic logic [11:0] ref_cw(int t, logic [3:0] op);
      logic cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo;
      cp = 0; ep = 0; ea = 0; su = 0; eu = 0;
      lm = 1; ce = 1; li = 1; ei = 1; la = 1; lb = 1; lo = 1;
      case (t)
         1: begin ep = 1; lm = 0; end
         2: cp = 1;
         3: begin ce = 0; li = 0; end
         4: if (op == 4'd0 || op == 4'd1 || op == 4'd2) begin ei = 0; lm = 0; end
            else if (op == 4'd14) begin ea = 1; lo = 0; end
         5: if (op == 4'd0) begin ce = 0; la = 0; end
            else if (op == 4'd1 || op == 4'd2) begin ce = 0; lb = 0; su = (op == 4'd2); end
         6: if (op == 4'd1 || op == 4'd2) begin eu = 1; la = 0; su = (op == 4'd2); end
         default: ;
      endcase
      return {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo};
   endfunction

   function automatic logic [3:0] pick_op();
      int r;
      if (plan_q.size() > 0) return plan_q.pop_front();
      r = $urandom_range(0, 19);
      if (r < 4)  return 4'd0;
      if (r < 8)  return 4'd1;
      if (r < 12) return 4'd2;
      if (r < 15) return 4'd14;
      if (r == 15) return 4'd15;
      return 4'($urandom_range(3, 13));
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic push_exp();
      exp_t e;
      e.ts  = 6'(1) << (m_t - 1);
      e.hlt = m_halted || (m_t == 4 && op_rand == 4'd15);
      e.cw  = (e.hlt || !nCLR) ? ref_cw(0, 4'd0) : ref_cw(m_t, op_rand);
      exp_q.push_back(e);
   endtask

   task automatic step();
      @(negedge CLK);
      if (!nCLR) begin
         m_t = 1; m_halted = 0; m_instr = pick_op();
      end else if (m_force) begin
         m_force = 0; m_t = 1; m_instr = pick_op();
      end else if (m_halted) begin
         m_halted = 1;
      end else if (m_t == 4 && op_rand == 4'd15) begin
         m_halted = 1;
      end else if (m_t == 6) begin
         m_t = 1; m_instr = pick_op();
      end else begin
         m_t++;
      end
      #1;
      if (m_halted || (m_t <= 3 && garbage_en)) op_rand = 4'($urandom_range(0, 15));
      else                                      op_rand = m_instr;
      push_exp();
   endtask

   task automatic abort_pulse();
      @(posedge CLK);
      #1 nCLR = 1'b0;
      #1 chk("abort_now", {13'd0, TSTATE, act_cw, HLT}, {13'd0, 6'b000001, ref_cw(0, 4'd0), 1'b0});
      step();
      @(posedge CLK);
      #1 nCLR = 1'b1;
   endtask

   task automatic force_illegal();
      @(posedge CLK);
      #1 force dut.u_ring.r_state = 6'b000011;
      #1 release dut.u_ring.r_state;
      m_force = 1;
   endtask

   // Scoreboard monitor, sampling on the posedge, away from the negedge where the ring moves
   exp_t e_mon;
   int   nd, nl;
   always @(posedge CLK) begin
      if (!dp_mode && exp_q.size() > 0) begin
         e_mon = exp_q.pop_front();
         checks++;
         if ({TSTATE, act_cw, HLT} !== {e_mon.ts, e_mon.cw, e_mon.hlt}) begin
            errors++;
            $display("FAIL sb ts=%b cw=%h hlt=%b expected ts=%b cw=%h hlt=%b",
                     TSTATE, act_cw, HLT, e_mon.ts, e_mon.cw, e_mon.hlt);
         end
         nd = int'(Ep) + int'(!nCE) + int'(!nEi) + int'(Ea) + int'(Eu);
         nl = int'(!nLm) + int'(!nLi) + int'(!nLa) + int'(!nLb) + int'(!nLo);
         checks++;
         if (nd > 1 || nl > 1) begin
            errors++;
            $display("FAIL invariant drivers=%0d loads=%0d allowed 1 each", nd, nl);
         end
      end
   end

   // Behavioural datapath driven by the controller outputs
   logic [3:0] pc, mar;
   logic [7:0] ir, acc, breg, outr, bus;
   logic [7:0] ram [16];

   always_comb begin
      bus = 8'h00;
      if (Ep)        bus = {4'h0, pc};
      else if (!nCE) bus = ram[mar];
      else if (!nEi) bus = {4'h0, ir[3:0]};
      else if (Ea)   bus = acc;
      else if (Eu)   bus = Su ? acc - breg : acc + breg;
   end

   always @(posedge CLK or negedge nCLR) begin
      if (!nCLR) begin
         pc <= 4'h0; mar <= 4'h0; ir <= 8'h00;
      end else if (dp_mode) begin
         if (Cp)   pc   <= pc + 4'h1;
         if (!nLm) mar  <= bus[3:0];
         if (!nLi) ir   <= bus;
         if (!nLa) acc  <= bus;
         if (!nLb) breg <= bus;
         if (!nLo) outr <= bus;
      end
   end

   assign op_w = dp_mode ? ir[7:4] : op_rand;

   logic [7:0] exp_acc, acc_before;
   bit         found;

   initial begin
      nCLR = 1'b0; op_rand = 4'd0; dp_mode = 0; garbage_en = 0;
      m_t = 1; m_halted = 0; m_force = 0; m_instr = 4'd0; hcnt = 0;
      plan_q = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd5, 4'd15};
      step();
      @(posedge CLK);
      #1 nCLR = 1'b1;

      for (int c = 0; c < 1500; c++) begin
         garbage_en = (c >= 40);
         step();
         if (m_halted) begin
            hcnt++;
            if (hcnt >= 20) begin
               hcnt = 0;
               abort_pulse();
            end
         end else if (c > 40 && m_t == 5 && $urandom_range(0, 15) == 0) begin
            abort_pulse();
         end else if (c > 40 && m_t == 2 && $urandom_range(0, 31) == 0) begin
            force_illegal();
         end
      end
      @(posedge CLK);
      #1;

      // Program LDA 9, ADD A, SUB B, OUT, HLT
      for (int i = 0; i < 16; i++) ram[i] = 8'h00;
      ram[0] = 8'h09; ram[1] = 8'h1A; ram[2] = 8'h2B; ram[3] = 8'hE0; ram[4] = 8'hF0;
      ram[9] = 8'h05; ram[10] = 8'h03; ram[11] = 8'($urandom_range(0, 255));
      exp_acc = ram[9] + ram[10] - ram[11];
      dp_mode = 1;
      nCLR = 1'b0;
      #3 nCLR = 1'b1;
      for (int i = 0; i < 100 && HLT !== 1'b1; i++) @(posedge CLK);
      #1;
      chk("prog_halt", {31'd0, HLT}, 32'd1);
      chk("prog_acc", {24'd0, acc}, {24'd0, exp_acc});
      chk("prog_out", {24'd0, outr}, {24'd0, exp_acc});
      chk("prog_tstate", {26'd0, TSTATE}, {26'd0, 6'b001000});

      // LDA aborted in T5 before its load edge must leave ACC untouched
      acc_before = acc;
      ram[0] = 8'h0C; ram[12] = ~acc_before;
      @(posedge CLK);
      #1 nCLR = 1'b0;
      #2 nCLR = 1'b1;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge CLK);
         #1;
         if (TSTATE === 6'b010000) found = 1;
      end
      chk("reach_t5", {31'd0, found}, 32'd1);
      nCLR = 1'b0;
      #1 chk("dp_abort", {13'd0, TSTATE, act_cw, HLT}, {13'd0, 6'b000001, ref_cw(0, 4'd0), 1'b0});
      @(posedge CLK);
      #1 chk("acc_kept", {24'd0, acc}, {24'd0, acc_before});
      nCLR = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
